sys_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream system-bus master port (the port feeding the address-decoding interconnect) between MN independent upstream masters, e.g. the PS GP port and internal sequencer/DMA engines. Each upstream single-cycle read or write pulse is latched, granted in round-robin order, and replayed downstream as a single-cycle pulse. The matching ack, err and rdata are routed back to the originating master only. An optional watchdog completes hung transactions with an error.

---
 rtl/sys_bus_arb_pkg.sv | 33 +++
 rtl/sys_bus_rr_pick.sv | 35 +++
 rtl/sys_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sys_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_arb_pkg.sv
// Shared types and constants for the system-bus arbiter.
// Optional watchdog feature macro: SYS_BUS_ARB_TIMEOUT_EN.
package sys_bus_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Operation stored in a pending slot
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Read data returned on a watchdog-completed transaction
    localparam logic [31:0] TMO_RDATA = 32'hDEAD_BEEF;

    // Default watchdog limit (cycles after downstream issue)
    localparam int TMO_DEFAULT = 255;

    // Width of the watchdog counter
    localparam int TMO_CNT_W = 16;

    // Index width for an n-entry one-hot vector (at least one bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_bus_rr_pick.sv
// Combinational round-robin pick: first valid entry at or after ptr+1 (mod MN).
// Returns a one-hot grant, its index, and whether anything was valid.
module sys_bus_rr_pick
    import sys_bus_arb_pkg::*;
#(
    parameter int MN = 2,
    parameter int PW = idx_w(MN)
) (
    input  logic [MN-1:0] valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [MN-1:0] grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    // Scan MN positions starting just after the last owner; first hit wins
    always_comb begin
        logic found;
        int   j;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int off = 1; off <= MN; off++) begin
            j = (int'(ptr_i) + off) % MN;
            if (!found && valid_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = PW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one downstream system-bus master port between
// MN upstream masters. Each upstream pulse is latched in a per-master slot,
// granted in round-robin order, replayed downstream as a one-cycle pulse, and
// the response is routed back to the originating master only.
// Optional watchdog: define SYS_BUS_ARB_TIMEOUT_EN to complete hung
// transactions with err=1 after TMO cycles.
//
// Handshake: every upstream request is a one-cycle pulse on m_wen_i/m_ren_i;
// downstream s_wen_o/s_ren_o is a one-cycle pulse and the slave answers with
// s_ack_i (accepted in the issue cycle or any later cycle until answered);
// the master sees a one-cycle m_ack_o with m_err_o/m_rdata_o valid alongside.
module sys_bus_arbiter
    import sys_bus_arb_pkg::*;
#(
    parameter int MN  = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [MN*AW-1:0] m_addr_i,
    input  logic [MN*DW-1:0] m_wdata_i,
    input  logic [MN-1:0]    m_wen_i,
    input  logic [MN-1:0]    m_ren_i,
    output logic [DW-1:0]    m_rdata_o,
    output logic [MN-1:0]    m_ack_o,
    output logic [MN-1:0]    m_err_o,
    output logic [AW-1:0]    s_addr_o,
    output logic [DW-1:0]    s_wdata_o,
    output logic             s_wen_o,
    output logic             s_ren_o,
    input  logic [DW-1:0]    s_rdata_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    output logic [MN-1:0]    grant_o,
    output logic [MN-1:0]    drop_o,
    output logic [1:0]       dbg_state_o
);

    localparam int PW = idx_w(MN);
    localparam logic [DW-1:0]        TMO_RDATA_DW = DW'(TMO_RDATA);
    localparam logic [TMO_CNT_W-1:0] TMO_LIM      = TMO_CNT_W'(TMO);

    // FSM
    state_e state_q, state_d;

    // Pending slots
    logic [MN-1:0] slot_valid_q, slot_valid_d;
    logic [AW-1:0] slot_addr_q  [MN];
    logic [AW-1:0] slot_addr_d  [MN];
    logic [DW-1:0] slot_wdata_q [MN];
    logic [DW-1:0] slot_wdata_d [MN];
    op_e           slot_op_q    [MN];
    op_e           slot_op_d    [MN];
    logic [MN-1:0] drop_q, drop_d;

    // Arbitration state
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gidx_q, gidx_d;
    logic [MN-1:0] grant_q, grant_d;

    // Registered downstream and upstream outputs
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic          s_wen_q, s_wen_d;
    logic          s_ren_q, s_ren_d;
    logic [MN-1:0] m_ack_q, m_ack_d;
    logic [MN-1:0] m_err_q, m_err_d;
    logic [DW-1:0] m_rdata_q, m_rdata_d;

    // Picker results
    logic [MN-1:0] pick_grant;
    logic [PW-1:0] pick_idx;
    logic          pick_any;

    // Response qualification
    logic          tmo_hit;
    logic          resp_enter;
    logic          resp_err;
    logic [DW-1:0] resp_rdata;

    sys_bus_rr_pick #(
        .MN (MN),
        .PW (PW)
    ) u_pick (
        .valid_i (slot_valid_q),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

`ifdef SYS_BUS_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] wdog_q, wdog_d, wdog_inc;
    logic                 wdog_busy;

    assign wdog_busy = (state_q == ISSUE) || (state_q == WAIT);
    assign wdog_inc  = wdog_q + TMO_CNT_W'(1);
    // Fire in the cycle whose increment reaches the limit, so RESP lands TMO cycles after issue
    assign tmo_hit   = wdog_busy && (wdog_inc == TMO_LIM);

    // Watchdog counter: cleared when entering ISSUE, counts through ISSUE and WAIT
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE && pick_any) begin
            wdog_d = '0;
        end else if (wdog_busy) begin
            wdog_d = wdog_inc;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^TMO_LIM;
`endif

    // An ack beats a timeout in the same cycle; acks outside ISSUE/WAIT are ignored
    assign resp_enter = ((state_q == ISSUE) || (state_q == WAIT)) && (s_ack_i || tmo_hit);
    assign resp_err   = s_ack_i ? s_err_i   : 1'b1;
    assign resp_rdata = s_ack_i ? s_rdata_i : TMO_RDATA_DW;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   state_d = resp_enter ? RESP : WAIT;
            WAIT:    if (resp_enter) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered grant, downstream and response outputs
    always_comb begin
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wen_d   = 1'b0;
        s_ren_d   = 1'b0;
        m_ack_d   = '0;
        m_err_d   = '0;
        m_rdata_d = m_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d   = pick_grant;
                    gidx_d    = pick_idx;
                    s_addr_d  = slot_addr_q[pick_idx];
                    s_wdata_d = slot_wdata_q[pick_idx];
                    s_wen_d   = (slot_op_q[pick_idx] == OP_WR);
                    s_ren_d   = (slot_op_q[pick_idx] == OP_RD);
                end
            end
            ISSUE, WAIT: begin
                if (resp_enter) begin
                    m_ack_d   = grant_q;
                    m_err_d   = resp_err ? grant_q : '0;
                    m_rdata_d = resp_rdata;
                end
            end
            RESP: begin
                grant_d = '0;
                ptr_d   = gidx_q;
            end
            default: ;
        endcase
    end

    // Slot bookkeeping: release the served slot, then load or drop new pulses (a load in the release cycle wins)
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        slot_op_d    = slot_op_q;
        drop_d       = drop_q;
        for (int i = 0; i < MN; i++) begin
            if (state_q == RESP && gidx_q == PW'(i)) begin
                slot_valid_d[i] = 1'b0;
            end
            if (m_wen_i[i] || m_ren_i[i]) begin
                if (slot_valid_d[i]) begin
                    drop_d[i] = 1'b1;
                end else begin
                    slot_valid_d[i] = 1'b1;
                    slot_addr_d[i]  = m_addr_i[i*AW +: AW];
                    slot_wdata_d[i] = m_wdata_i[i*DW +: DW];
                    slot_op_d[i]    = m_wen_i[i] ? OP_WR : OP_RD;
                end
            end
        end
    end

    // Datapath and slot registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid_q <= '0;
            drop_q       <= '0;
            for (int i = 0; i < MN; i++) begin
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
                slot_op_q[i]    <= OP_RD;
            end
            ptr_q     <= PW'(MN - 1);
            gidx_q    <= '0;
            grant_q   <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wen_q   <= 1'b0;
            s_ren_q   <= 1'b0;
            m_ack_q   <= '0;
            m_err_q   <= '0;
            m_rdata_q <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            drop_q       <= drop_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            slot_op_q    <= slot_op_d;
            ptr_q        <= ptr_d;
            gidx_q       <= gidx_d;
            grant_q      <= grant_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_wen_q      <= s_wen_d;
            s_ren_q      <= s_ren_d;
            m_ack_q      <= m_ack_d;
            m_err_q      <= m_err_d;
            m_rdata_q    <= m_rdata_d;
        end
    end

    assign m_rdata_o   = m_rdata_q;
    assign m_ack_o     = m_ack_q;
    assign m_err_o     = m_err_q;
    assign s_addr_o    = s_addr_q;
    assign s_wdata_o   = s_wdata_q;
    assign s_wen_o     = s_wen_q;
    assign s_ren_o     = s_ren_q;
    assign grant_o     = grant_q;
    assign drop_o      = drop_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed testbench for sys_bus_arbiter (MN=2, AW=DW=32, TMO=4).
// Define SYS_BUS_ARB_TIMEOUT_EN for both RTL and bench to include the watchdog step.
module tb_sys_bus_arbiter;

    localparam int MN  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam int W   = 2*MN + DW;

    localparam logic [DW-1:0] RD_MASK = 32'h5A5A_0000;
    localparam logic [AW-1:0] A0      = 32'h0000_0100;
    localparam logic [AW-1:0] A1      = 32'h0000_0200;

    // ---------------- clock / reset / DUT ----------------
    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [MN*AW-1:0] m_addr_i;
    logic [MN*DW-1:0] m_wdata_i;
    logic [MN-1:0]    m_wen_i;
    logic [MN-1:0]    m_ren_i;
    logic [DW-1:0]    m_rdata_o;
    logic [MN-1:0]    m_ack_o;
    logic [MN-1:0]    m_err_o;
    logic [AW-1:0]    s_addr_o;
    logic [DW-1:0]    s_wdata_o;
    logic             s_wen_o;
    logic             s_ren_o;
    logic [DW-1:0]    s_rdata_i;
    logic             s_ack_i;
    logic             s_err_i;
    logic [MN-1:0]    grant_o;
    logic [MN-1:0]    drop_o;
    logic [1:0]       dbg_state_o;

    always #5 clk_i = ~clk_i;

    sys_bus_arbiter #(
        .MN  (MN),
        .AW  (AW),
        .DW  (DW),
        .TMO (TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m_addr_i    (m_addr_i),
        .m_wdata_i   (m_wdata_i),
        .m_wen_i     (m_wen_i),
        .m_ren_i     (m_ren_i),
        .m_rdata_o   (m_rdata_o),
        .m_ack_o     (m_ack_o),
        .m_err_o     (m_err_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_wen_o     (s_wen_o),
        .s_ren_o     (s_ren_o),
        .s_rdata_i   (s_rdata_i),
        .s_ack_i     (s_ack_i),
        .s_err_i     (s_err_i),
        .grant_o     (grant_o),
        .drop_o      (drop_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_mis = 0;
    logic         auto_ack = 1'b0;
    logic         ack_pend = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_m(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_addr_i[i*AW +: AW]  = a;
        m_wdata_i[i*DW +: DW] = d;
    endtask

    // Advance one clock; optional auto-acking slave (ack one cycle after issue); check every upstream ack
    task automatic cycle();
        @(posedge clk_i);
        #1;
        if (auto_ack) begin
            s_ack_i = ack_pend;
            if (ack_pend) s_rdata_i = s_addr_o ^ RD_MASK;
            ack_pend = s_wen_o | s_ren_o;
        end
        if (m_ack_o !== '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 64'(m_ack_o), 64'h0);
            end else begin
                check("sb_resp", 64'({m_ack_o, m_err_o, m_rdata_o}), 64'(exp_q.pop_front()));
            end
        end
    endtask

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int reqs;
        int acks;
        logic [MN-1:0] exp_g;

        rst_i     = 1'b1;
        m_addr_i  = '0;
        m_wdata_i = '0;
        m_wen_i   = '0;
        m_ren_i   = '0;
        s_rdata_i = '0;
        s_ack_i   = 1'b0;
        s_err_i   = 1'b0;

        // Reset state
        cycle();
        cycle();
        check("rst_grant", 64'(grant_o), 64'h0);
        check("rst_swen", 64'(s_wen_o), 64'h0);
        check("rst_sren", 64'(s_ren_o), 64'h0);
        check("rst_saddr", 64'(s_addr_o), 64'h0);
        check("rst_mack", 64'(m_ack_o), 64'h0);
        check("rst_drop", 64'(drop_o), 64'h0);
        check("rst_rdata", 64'(m_rdata_o), 64'h0);
        check("rst_state", 64'(dbg_state_o), 64'h0);
        rst_i = 1'b0;
        cycle();

        // Single write, slave acks one cycle after issue
        set_m(0, 32'h4010_0004, 32'h0000_1234);
        m_wen_i = 2'b01;                                  // c0
        cycle(); m_wen_i = '0;                            // c1
        check("t1_c1_grant", 64'(grant_o), 64'h0);
        check("t1_c1_swen", 64'(s_wen_o), 64'h0);
        cycle();                                          // c2 ISSUE
        check("t1_grant", 64'(grant_o), 64'h1);
        check("t1_swen", 64'(s_wen_o), 64'h1);
        check("t1_sren", 64'(s_ren_o), 64'h0);
        check("t1_saddr", 64'(s_addr_o), 64'h4010_0004);
        check("t1_swdata", 64'(s_wdata_o), 64'h1234);
        cycle();                                          // c3 WAIT
        check("t1_swen_pulse", 64'(s_wen_o), 64'h0);
        check("t1_saddr_hold", 64'(s_addr_o), 64'h4010_0004);
        check("t1_state_wait", 64'(dbg_state_o), 64'h2);
        s_ack_i = 1'b1; s_rdata_i = 32'hCAFE_0001;
        exp_q.push_back({2'b01, 2'b00, 32'hCAFE_0001});
        cycle();                                          // c4 RESP
        s_ack_i = 1'b0;
        check("t1_mack", 64'(m_ack_o), 64'h1);
        check("t1_merr", 64'(m_err_o), 64'h0);
        cycle();                                          // c5
        check("t1_mack_pulse", 64'(m_ack_o), 64'h0);
        check("t1_grant_clr", 64'(grant_o), 64'h0);
        check("t1_rdata_hold", 64'(m_rdata_o), 64'hCAFE_0001);

        // wen+ren together is a write; zero-wait ack carrying an error
        set_m(1, 32'h8000_0010, 32'h0000_A5A5);
        m_wen_i = 2'b10; m_ren_i = 2'b10;                 // c0
        cycle(); m_wen_i = '0; m_ren_i = '0;              // c1
        cycle();                                          // c2 ISSUE
        check("t2_grant", 64'(grant_o), 64'h2);
        check("t2_swen", 64'(s_wen_o), 64'h1);
        check("t2_sren", 64'(s_ren_o), 64'h0);
        s_ack_i = 1'b1; s_err_i = 1'b1; s_rdata_i = 32'h1111_2222;
        exp_q.push_back({2'b10, 2'b10, 32'h1111_2222});
        cycle();                                          // c3 RESP
        s_ack_i = 1'b0; s_err_i = 1'b0;
        check("t2_mack", 64'(m_ack_o), 64'h2);
        check("t2_merr", 64'(m_err_o), 64'h2);
        cycle();
        check("t2_mack_pulse", 64'(m_ack_o), 64'h0);
        cycle();

        // Contention: both read in the same cycle, master 0 first
        set_m(0, A0, '0);
        set_m(1, A1, '0);
        auto_ack = 1'b1; ack_pend = 1'b0;
        exp_q.push_back({2'b01, 2'b00, A0 ^ RD_MASK});
        exp_q.push_back({2'b10, 2'b00, A1 ^ RD_MASK});
        m_ren_i = 2'b11;                                  // c0
        cycle(); m_ren_i = '0;                            // c1
        check("t3_c1_grant", 64'(grant_o), 64'h0);
        cycle();                                          // c2
        check("t3_grant0", 64'(grant_o), 64'h1);
        check("t3_sren0", 64'(s_ren_o), 64'h1);
        check("t3_saddr0", 64'(s_addr_o), 64'(A0));
        cycle();                                          // c3
        cycle();                                          // c4 RESP
        check("t3_mack0", 64'(m_ack_o), 64'h1);
        cycle();                                          // c5 IDLE
        check("t3_grant_gap", 64'(grant_o), 64'h0);
        check("t3_sren_gap", 64'(s_ren_o), 64'h0);
        cycle();                                          // c6 ISSUE
        check("t3_grant1", 64'(grant_o), 64'h2);
        check("t3_sren1", 64'(s_ren_o), 64'h1);
        check("t3_saddr1", 64'(s_addr_o), 64'(A1));
        cycle();                                          // c7
        cycle();                                          // c8 RESP
        check("t3_mack1", 64'(m_ack_o), 64'h2);
        cycle();
        check("t3_idle_grant", 64'(grant_o), 64'h0);

        // Fairness: both re-request on every ack, 8 transactions alternate 0,1,0,1...
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) exp_q.push_back({2'b01, 2'b00, A0 ^ RD_MASK});
            else            exp_q.push_back({2'b10, 2'b00, A1 ^ RD_MASK});
        end
        reqs = 2; acks = 0; exp_g = 2'b01;
        m_ren_i = 2'b11;
        for (int c = 0; c < 200 && acks < 8; c++) begin
            cycle();
            m_ren_i = '0;
            if (s_ren_o) begin
                check("fair_grant", 64'(grant_o), 64'(exp_g));
                exp_g = ~exp_g;
            end
            if (m_ack_o != '0) begin
                acks++;
                if (reqs < 8) begin
                    m_ren_i = m_ack_o;
                    reqs++;
                end
            end
        end
        check("fair_done", 64'(acks), 64'd8);
        auto_ack = 1'b0; s_ack_i = 1'b0;
        cycle(); cycle(); cycle();
        check("fair_sb_empty", 64'(exp_q.size()), 64'h0);

        // Drop: second write while slot 1 is pending
        set_m(1, A1, 32'h0000_1111);
        m_wen_i = 2'b10;                                  // c0
        cycle();                                          // c1
        check("t5_drop_before", 64'(drop_o), 64'h0);
        set_m(1, A1, 32'h0000_2222);                      // dropped pulse
        cycle(); m_wen_i = '0;                            // c2 ISSUE
        check("t5_drop", 64'(drop_o), 64'h2);
        check("t5_swen", 64'(s_wen_o), 64'h1);
        check("t5_swdata", 64'(s_wdata_o), 64'h1111);
        check("t5_grant", 64'(grant_o), 64'h2);
        cycle();                                          // c3 WAIT
        s_ack_i = 1'b1; s_rdata_i = 32'h0BAD_F00D;
        exp_q.push_back({2'b10, 2'b00, 32'h0BAD_F00D});
        cycle();                                          // c4 RESP
        s_ack_i = 1'b0;
        check("t5_mack", 64'(m_ack_o), 64'h2);
        cycle(); cycle(); cycle(); cycle();
        check("t5_one_ack", 64'(exp_q.size()), 64'h0);
        check("t5_idle", 64'(dbg_state_o), 64'h0);
        check("t5_drop_sticky", 64'(drop_o), 64'h2);

`ifdef SYS_BUS_ARB_TIMEOUT_EN
        // Watchdog: read with no ack completes with error 4 cycles after issue
        set_m(1, A1, '0);
        m_ren_i = 2'b10;                                  // c0
        cycle(); m_ren_i = '0;                            // c1
        cycle();                                          // c2 ISSUE
        check("t6_sren", 64'(s_ren_o), 64'h1);
        cycle(); cycle(); cycle();                        // c3..c5
        check("t6_no_ack_yet", 64'(m_ack_o), 64'h0);
        exp_q.push_back({2'b10, 2'b10, 32'hDEAD_BEEF});
        cycle();                                          // c6 RESP
        check("t6_mack", 64'(m_ack_o), 64'h2);
        check("t6_merr", 64'(m_err_o), 64'h2);
        check("t6_rdata", 64'(m_rdata_o), 64'hDEAD_BEEF);
        cycle();                                          // c7 stray ack
        s_ack_i = 1'b1;
        cycle(); s_ack_i = 1'b0;
        cycle(); cycle();
        check("t6_stray_ignored", 64'(exp_q.size()), 64'h0);
        check("t6_idle", 64'(dbg_state_o), 64'h0);
`endif

        // Reset during WAIT aborts the transaction
        set_m(0, A0, '0);
        m_ren_i = 2'b01;                                  // c0
        cycle(); m_ren_i = '0;                            // c1
        cycle();                                          // c2 ISSUE
        cycle();                                          // c3 WAIT
        check("t7_wait", 64'(dbg_state_o), 64'h2);
        rst_i = 1'b1;
        #1;
        check("t7_rst_grant", 64'(grant_o), 64'h0);
        check("t7_rst_saddr", 64'(s_addr_o), 64'h0);
        check("t7_rst_drop", 64'(drop_o), 64'h0);
        check("t7_rst_rdata", 64'(m_rdata_o), 64'h0);
        check("t7_rst_state", 64'(dbg_state_o), 64'h0);
        cycle();
        rst_i = 1'b0;
        s_ack_i = 1'b1;                                   // late ack
        cycle(); s_ack_i = 1'b0;
        cycle(); cycle();
        check("t7_no_ack", 64'(m_ack_o), 64'h0);
        check("t7_idle_grant", 64'(grant_o), 64'h0);
        set_m(0, A0, 32'h0000_0077);
        auto_ack = 1'b1; ack_pend = 1'b0;
        exp_q.push_back({2'b01, 2'b00, A0 ^ RD_MASK});
        m_wen_i = 2'b01;
        cycle(); m_wen_i = '0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) cycle();
        check("t7_recover", 64'(exp_q.size()), 64'h0);
        auto_ack = 1'b0; s_ack_i = 1'b0;
        cycle(); cycle();

        // Final report
        check("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
